// File: rtl/pool_ctrl_pkg.sv
// rtl/pool_ctrl_pkg.sv - pkg_pooling: pooling unit geometry tables, widths and sequencer state type
package pkg_pooling;

    localparam int POOLUNITS      = 1;
    localparam int ACT_BITS       = 3;
    localparam int PARALLEL_MAX   = 2;
    localparam int PARALLEL_CONFS = 2;

    // Tables indexed [unit id][conf][slice][0 = first row, 1 = last row]
    localparam int KER_SIZE [2:POOLUNITS+1] = '{2};
    localparam int PARALLEL_NUM [2:POOLUNITS+1][PARALLEL_CONFS] = '{'{1, 2}};
    localparam int PARALLEL_IN [2:POOLUNITS+1][PARALLEL_CONFS][PARALLEL_MAX][2] =
        '{'{'{'{0, 27}, '{0, 0}}, '{'{0, 9}, '{10, 19}}}};
    localparam int PARALLEL_OUT [2:POOLUNITS+1][PARALLEL_CONFS][PARALLEL_MAX][2] =
        '{'{'{'{0, 13}, '{0, 0}}, '{'{0, 4}, '{5, 9}}}};

    function automatic int max_row();
        int m = 0;
        for (int u = 2; u <= POOLUNITS + 1; u++)
            for (int c = 0; c < PARALLEL_CONFS; c++)
                for (int n = 0; n < PARALLEL_MAX; n++)
                    for (int e = 0; e < 2; e++) begin
                        if (PARALLEL_IN[u][c][n][e] > m)  m = PARALLEL_IN[u][c][n][e];
                        if (PARALLEL_OUT[u][c][n][e] > m) m = PARALLEL_OUT[u][c][n][e];
                    end
        return m;
    endfunction

    localparam int ROW_W = $clog2(max_row() + 1);
    localparam int BIT_W = $clog2(ACT_BITS);

    // Index of the final output row: the longest slice decides when the layer ends
    function automatic int last_row(input int id, input int c);
        int m = 0;
        for (int n = 0; n < PARALLEL_MAX; n++)
            if (n < PARALLEL_NUM[id][c] &&
                PARALLEL_OUT[id][c][n][1] - PARALLEL_OUT[id][c][n][0] > m)
                m = PARALLEL_OUT[id][c][n][1] - PARALLEL_OUT[id][c][n][0];
        return m;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } pool_ctrl_state_t;

endpackage

// File: rtl/pool_ctrl_delay.sv
// rtl/pool_ctrl_delay.sv - DEPTH-stage shift register aligning read strobes to memory latency
module pool_ctrl_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - pooling unit sequencer: reads, datapath strobes, output writes
// Define POOL_CTRL_PERF_EN to add the saturating write-stall counter output stall_cnt.
module pool_ctrl
    import pkg_pooling::*;
#(
    parameter int ID      = 2,
    parameter int MEM_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 conf,
    output logic                                 busy,
    output logic                                 done,
    output logic [PARALLEL_MAX-1:0]              rd_en,
    output logic [PARALLEL_MAX-1:0][ROW_W-1:0]   rd_row,
    output logic [BIT_W-1:0]                     rd_bit,
    output logic                                 pool_clear,
    output logic [PARALLEL_MAX-1:0]              pool_en,
    output logic [PARALLEL_MAX-1:0]              wr_en,
    output logic [PARALLEL_MAX-1:0][ROW_W-1:0]   wr_row,
`ifdef POOL_CTRL_PERF_EN
    output logic [15:0]                          stall_cnt,
`endif
    input  logic                                 wr_rdy
);

    localparam int KER   = KER_SIZE[ID];
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    pool_ctrl_state_t state;
    logic             conf_q;
    logic [ROW_W-1:0] i_q;
    logic [ROW_W-1:0] k_q;
    logic [BIT_W-1:0] b_q;
    logic [LAT_W-1:0] lat_q;
    logic [ROW_W-1:0] last_i;
    logic             wr_hs;
    logic             first_rd;

    logic [PARALLEL_MAX-1:0] active;
    logic [ROW_W:0]          out_ext;
    logic [PARALLEL_MAX:0]   dly_in;
    logic [PARALLEL_MAX:0]   dly_out;

    assign last_i = ROW_W'(last_row(ID, int'(conf_q)));
    assign wr_hs  = (|wr_en) && wr_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            conf_q <= 1'b0;
            i_q    <= '0;
            k_q    <= '0;
            b_q    <= '0;
            lat_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_READ;
                        conf_q <= conf;
                        i_q    <= '0;
                        k_q    <= '0;
                        b_q    <= BIT_W'(ACT_BITS - 1);
                    end
                end
                S_READ: begin
                    if (b_q == '0) begin
                        b_q <= BIT_W'(ACT_BITS - 1);
                        if (k_q == ROW_W'(KER - 1)) begin
                            k_q   <= '0;
                            lat_q <= '0;
                            state <= S_DRAIN;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else begin
                        b_q <= b_q - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (lat_q == LAT_W'(MEM_LAT - 1)) state <= S_WRITE;
                    else                              lat_q <= lat_q + 1'b1;
                end
                S_WRITE: begin
                    if (wr_hs) begin
                        if (i_q == last_i) begin
                            state <= S_FIN;
                        end else begin
                            i_q   <= i_q + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Slice mask and row addresses; one extra bit keeps the row-range compare from wrapping
    always_comb begin
        active  = '0;
        rd_en   = '0;
        rd_row  = '0;
        wr_en   = '0;
        wr_row  = '0;
        rd_bit  = '0;
        out_ext = '0;
        for (int n = 0; n < PARALLEL_MAX; n++) begin
            out_ext = (ROW_W+1)'(PARALLEL_OUT[ID][conf_q][n][0]) + {1'b0, i_q};
            if (n < PARALLEL_NUM[ID][conf_q] &&
                out_ext <= (ROW_W+1)'(PARALLEL_OUT[ID][conf_q][n][1]))
                active[n] = 1'b1;
            if (state == S_READ && active[n]) begin
                rd_en[n]  = 1'b1;
                rd_row[n] = ROW_W'(PARALLEL_IN[ID][conf_q][n][0]) + i_q * ROW_W'(KER) + k_q;
            end
            if (state == S_WRITE && active[n]) begin
                wr_en[n]  = 1'b1;
                wr_row[n] = out_ext[ROW_W-1:0];
            end
        end
        if (state == S_READ) rd_bit = b_q;
    end

    assign first_rd = (state == S_READ) && (k_q == '0) &&
                      (b_q == BIT_W'(ACT_BITS - 1)) && (|rd_en);
    assign dly_in   = {rd_en, first_rd};

    pool_ctrl_delay #(
        .DEPTH (MEM_LAT),
        .W     (PARALLEL_MAX + 1)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in),
        .dout (dly_out)
    );

    assign pool_en    = dly_out[PARALLEL_MAX:1];
    assign pool_clear = dly_out[0];
    assign busy       = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
    assign done       = (state == S_FIN);

`ifdef POOL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start))
            stall_cnt <= '0;
        else if (state == S_WRITE && !wr_rdy && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// tb/tb_pool_ctrl.sv - self-checking bench for pool_ctrl (cycle schedule model, table + random runs)
module tb_pool_ctrl;
    import pkg_pooling::*;

    localparam int ID   = 2;
    localparam int LAT  = 2;
    localparam int PM   = PARALLEL_MAX;
    localparam int KER  = KER_SIZE[ID];
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst, start, conf, wr_rdy;
    logic busy, done, pool_clear;
    logic [PM-1:0]             rd_en, pool_en, wr_en;
    logic [PM-1:0][ROW_W-1:0]  rd_row, wr_row;
    logic [BIT_W-1:0]          rd_bit;
`ifdef POOL_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    int          exp_stall [MAXC];
    int          stall_ev  [MAXC];
`endif

    always #5 clk = ~clk;

    pool_ctrl #(.ID(ID), .MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .conf       (conf),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_bit     (rd_bit),
        .pool_clear (pool_clear),
        .pool_en    (pool_en),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
`ifdef POOL_CTRL_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .wr_rdy     (wr_rdy)
    );

    typedef struct packed {
        logic [PM-1:0]            rd_en;
        logic [PM-1:0][ROW_W-1:0] rd_row;
        logic [BIT_W-1:0]         rd_bit;
        logic                     pool_clear;
        logic [PM-1:0]            pool_en;
        logic [PM-1:0]            wr_en;
        logic [PM-1:0][ROW_W-1:0] wr_row;
        logic                     busy;
        logic                     done;
    } obs_t;

    typedef struct {
        int cf;
        int stall_at;
        int stall_len;
        int rst_at;
        int repulse_at;
        int exp_writes;
        int exp_done;
    } run_t;

    obs_t exp_v [MAXC];
    logic rdy_v [MAXC];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t sample();
        obs_t o;
        o.rd_en = rd_en; o.rd_row = rd_row; o.rd_bit = rd_bit;
        o.pool_clear = pool_clear; o.pool_en = pool_en;
        o.wr_en = wr_en; o.wr_row = wr_row; o.busy = busy; o.done = done;
        return o;
    endfunction

    task automatic chk_obs(input string nm, input int idx, input obs_t act, input obs_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int idx, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, req);
        end
    endtask

    // Schedule every output from the layer description: rows x kernel rows x bit-planes,
    // a drain gap, then a write held until the ready input is sampled high.
    task automatic build_model(input int cf, input int rst_at, output int done_c, output int nwr);
        int c = 1;
        int rows = 0;
        int lo, hi;
        logic [PM-1:0] mask;
        for (int j = 0; j < MAXC; j++) begin
            exp_v[j] = '0;
`ifdef POOL_CTRL_PERF_EN
            stall_ev[j] = 0;
`endif
        end
        for (int n = 0; n < PARALLEL_NUM[ID][cf]; n++) begin
            hi = PARALLEL_OUT[ID][cf][n][1] - PARALLEL_OUT[ID][cf][n][0] + 1;
            if (hi > rows) rows = hi;
        end
        for (int i = 0; i < rows; i++) begin
            mask = '0;
            for (int n = 0; n < PM; n++)
                if (n < PARALLEL_NUM[ID][cf] &&
                    PARALLEL_OUT[ID][cf][n][0] + i <= PARALLEL_OUT[ID][cf][n][1]) mask[n] = 1'b1;
            for (int k = 0; k < KER; k++)
                for (int b = ACT_BITS - 1; b >= 0; b--) begin
                    exp_v[c].busy   = 1'b1;
                    exp_v[c].rd_en  = mask;
                    exp_v[c].rd_bit = BIT_W'(b);
                    for (int n = 0; n < PM; n++)
                        if (mask[n]) exp_v[c].rd_row[n] = ROW_W'(PARALLEL_IN[ID][cf][n][0] + i * KER + k);
                    exp_v[c+LAT].pool_en    = mask;
                    exp_v[c+LAT].pool_clear = (k == 0 && b == ACT_BITS - 1);
                    c++;
                end
            for (int d = 0; d < LAT; d++) begin
                exp_v[c].busy = 1'b1;
                c++;
            end
            while (c < MAXC - 4) begin
                exp_v[c].busy  = 1'b1;
                exp_v[c].wr_en = mask;
                for (int n = 0; n < PM; n++) begin
                    lo = PARALLEL_OUT[ID][cf][n][0];
                    if (mask[n]) exp_v[c].wr_row[n] = ROW_W'(lo + i);
                end
                if (rdy_v[c]) break;
`ifdef POOL_CTRL_PERF_EN
                stall_ev[c] = 1;
`endif
                c++;
            end
            c++;
        end
        exp_v[c].done = 1'b1;
        done_c = c;
        if (rst_at > 0) begin
            for (int j = rst_at + 1; j < MAXC; j++) exp_v[j] = '0;
            if (done_c > rst_at) done_c = -1;
        end
        nwr = 0;
        for (int j = 0; j < MAXC; j++)
            if (exp_v[j].wr_en != '0 && rdy_v[j]) nwr++;
`ifdef POOL_CTRL_PERF_EN
        exp_stall[0] = 0;
        for (int j = 1; j < MAXC; j++)
            exp_stall[j] = (rst_at > 0 && j > rst_at) ? 0 : exp_stall[j-1] + stall_ev[j-1];
`endif
    endtask

    task automatic do_run(input int cf, input int rst_at, input int repulse_at,
                          output int done_seen, output int wr_seen, output int exp_done, output int exp_wr);
        int last;
        obs_t got;
        build_model(cf, rst_at, exp_done, exp_wr);
        last = ((exp_done > 0) ? exp_done : rst_at) + LAT + 3;
        done_seen = -1;
        wr_seen   = 0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start  = (c == 0) || (c == repulse_at);
            conf   = (c == repulse_at) ? !cf[0] : cf[0];
            rst    = (rst_at > 0 && c == rst_at);
            wr_rdy = rdy_v[c];
            @(negedge clk);
            got = sample();
            chk_obs("cycle", c, got, exp_v[c]);
`ifdef POOL_CTRL_PERF_EN
            if (c > 0) chk_int("stall_cnt", c, int'(stall_cnt), exp_stall[c]);
`endif
            if (got.done && done_seen < 0) done_seen = c;
            if (got.wr_en != '0 && wr_rdy) wr_seen++;
        end
        start = 1'b0;
        rst   = 1'b0;
        wr_rdy = 1'b1;
    endtask

    run_t tbl [5];

    initial begin
        int dseen, wseen, dexp, wexp;
        run_t r;

        tbl[0] = '{cf: 0, stall_at: 0,  stall_len: 0, rst_at: 0,  repulse_at: -1, exp_writes: 14, exp_done: 127};
        tbl[1] = '{cf: 1, stall_at: 0,  stall_len: 0, rst_at: 0,  repulse_at: -1, exp_writes: 5,  exp_done: 46};
        tbl[2] = '{cf: 0, stall_at: 45, stall_len: 3, rst_at: 0,  repulse_at: -1, exp_writes: 14, exp_done: 130};
        tbl[3] = '{cf: 0, stall_at: 0,  stall_len: 0, rst_at: 58, repulse_at: -1, exp_writes: 6,  exp_done: -1};
        tbl[4] = '{cf: 0, stall_at: 0,  stall_len: 0, rst_at: 0,  repulse_at: 20, exp_writes: 14, exp_done: 127};

        rst = 1'b1; start = 1'b0; conf = 1'b0; wr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_obs("reset", 0, sample(), '0);
`ifdef POOL_CTRL_PERF_EN
        chk_int("reset_stall", 0, int'(stall_cnt), 0);
`endif

        for (int t = 0; t < 5; t++) begin
            r = tbl[t];
            for (int j = 0; j < MAXC; j++) rdy_v[j] = 1'b1;
            for (int j = 0; j < r.stall_len; j++) rdy_v[r.stall_at + j] = 1'b0;
            do_run(r.cf, r.rst_at, r.repulse_at, dseen, wseen, dexp, wexp);
            chk_int("tbl_done", t, dseen, r.exp_done);
            chk_int("tbl_writes", t, wseen, r.exp_writes);
            chk_int("model_done", t, dexp, r.exp_done);
        end

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < MAXC; j++) rdy_v[j] = ($urandom_range(0, 3) != 0);
            do_run(int'($urandom_range(0, 1)), 0, int'($urandom_range(5, 40)),
                   dseen, wseen, dexp, wexp);
            chk_int("rnd_done", t, dseen, dexp);
            chk_int("rnd_writes", t, wseen, wexp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
